prbs_checker: RTL and testbench
===============================

Name: prbs_checker

Overview:
- Serial receiver/checker for the stream produced by the team's 8-bit Fibonacci LFSR generator. Generator rule: new bit = ^(state & tap), shifted into the LSB.
- Self-synchronises to the incoming bit stream, then flywheels a local copy of the LFSR and counts bit errors.
- Declares loss of lock when errors exceed a threshold.
- Sits at the far end of a link or loopback path for BIST and link-quality measurement.

Parameters:
- LOCK_CNT, 16, consecutive matching bits in VERIFY required to declare lock (1..255).
- WINDOW, 64, length of the loss-of-lock observation window, in valid bits (2..65535).
- LOSS_THRESH, 4, errors within one window that force loss of lock (1..WINDOW).
- CNT_W, 16, width of the saturating error counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous restart pulse: returns the checker to SEED, zeroes counters, re-samples tap.
- tap  in  8  feedback polynomial mask; must match the generator; sampled into tap_ff on reset release and on clear.
- bit_in  in  1  received serial bit.
- bit_valid  in  1  bit_in is valid this cycle; all state advances only on valid beats.
- locked  out  1  checker is synchronised (state == LOCKED).
- err_pulse  out  1  one-cycle pulse, asserted the cycle after a mismatching beat in LOCKED.
- err_count  out  CNT_W  total LOCKED-state errors since reset/clear; saturates at all-ones.

Behaviour:
- Reset (async, reset=1):
  - state=SEED; sr=0; fill_cnt=0; match_cnt=0; win_cnt=0; win_err=0.
  - locked=0, err_pulse=0, err_count=0.
  - tap_ff is loaded from tap while reset is high.
- Prediction: pred = ^(sr & tap_ff). sr[0] is the most recently accepted bit.
- All outputs are registered. locked is decoded from the state register.
- No valid beat: nothing changes; err_pulse returns to 0.
- SEED:
  - Each valid beat: sr <= {sr[6:0], bit_in}; fill_cnt++.
  - After the 8th valid beat: go to VERIFY, match_cnt=0.
- VERIFY:
  - Each valid beat: sr <= {sr[6:0], bit_in}, so sr always tracks the received bits (self-sync).
  - Match (bit_in==pred and sr!=0): match_cnt++. The beat on which match_cnt reaches LOCK_CNT moves the state to LOCKED; win_cnt and win_err are zeroed.
  - Mismatch, or sr==0 (all-zero lockup guard): match_cnt=0, stay in VERIFY.
  - No errors are counted in VERIFY.
- LOCKED (flywheel):
  - Each valid beat: sr <= {sr[6:0], pred}. The received bit is never shifted in, so a line error does not propagate.
  - Mismatch (bit_in!=pred): err_pulse=1 on the next cycle; err_count++ (saturating); win_err++.
  - win_cnt++ every valid beat. When win_cnt reaches WINDOW-1 on a beat, win_cnt=0 and win_err=0 next cycle. The error test on that same beat is evaluated before the window reset.
  - If win_err+mismatch reaches LOSS_THRESH: go to SEED, fill_cnt=0; locked=0 on the next cycle. err_count is retained.
- clear (sync) has priority over every state action, including a beat in the same cycle:
  - state=SEED; all counters=0; err_count=0; err_pulse=0; tap_ff<=tap.
- Reset mid-operation: all outputs drop immediately and asynchronously; resume in SEED once reset is released.
- Latency: locked rises on the clock edge of the (8+LOCK_CNT)-th valid beat after SEED, given an error-free stream.

Test Plan:
- Clean lock: generator model with tap=8'hB8, seed 8'h01, bit_valid=1 continuously, LOCK_CNT=16 -> locked=1 after exactly 24 valid beats; err_count stays 0 over 1000 further bits.
- Single error: after lock, invert one bit -> err_pulse high for exactly 1 cycle, the cycle after that beat; err_count=1; locked stays 1; next bits match (no error multiplication).
- Loss of lock: LOSS_THRESH=4, WINDOW=64; invert 4 bits within 20 beats -> locked falls the cycle after the 4th error; err_count=4; re-lock after 24 further clean beats.
- Window expiry: 3 errors, then 64 clean beats, then 3 more errors -> locked stays 1; err_count=6.
- All-zero line and gaps: bit_in=0 for 500 beats -> locked never rises. Clean stream with bit_valid toggling 1/0 -> lock after 24 valid beats (48 cycles).
- Reset/clear/saturation:
  - Assert reset while locked -> locked=0 and err_count=0 without a clock edge.
  - clear during VERIFY -> restart from SEED.
  - CNT_W=4 with 20 errors -> err_count holds at 15.

Source files
------------

// File: rtl/prbs_checker_if.sv
// Serial link bundle between a PRBS bit source and the prbs_checker.
//   bit_in     : received serial bit
//   bit_valid  : bit_in is valid this cycle
//   locked     : checker is synchronised to the stream
//   err_pulse  : one-cycle pulse after a mismatching beat while locked
//   err_count  : saturating count of locked-state bit errors
// The master drives the bits (link source / testbench); the slave is the checker.
interface prbs_checker_if #(
  parameter int CNT_W = 16
);
  logic             bit_in;
  logic             bit_valid;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] err_count;

  modport master (
    output bit_in,
    output bit_valid,
    input  locked,
    input  err_pulse,
    input  err_count
  );

  modport slave (
    input  bit_in,
    input  bit_valid,
    output locked,
    output err_pulse,
    output err_count
  );
endinterface

// File: rtl/prbs_checker.sv
// prbs_checker: receiver/checker for the 8-bit Fibonacci LFSR stream
// (new bit = ^(state & tap), shifted into the LSB).
//
// It fills a shift register from the line (SEED), confirms that the line
// obeys the polynomial for LOCK_CNT consecutive bits (VERIFY), then
// flywheels its own copy of the LFSR (LOCKED) and counts every received
// bit that disagrees with it. Too many errors inside one observation
// window drop it back to SEED.
//
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous, active-high reset
//   clear  : synchronous restart pulse (back to SEED, counters zeroed,
//            tap re-sampled); wins over a beat in the same cycle
//   tap    : feedback polynomial mask, captured into tap_q
//   link   : slave side of prbs_checker_if (bit_in/bit_valid in,
//            locked/err_pulse/err_count out, all outputs registered)
module prbs_checker #(
  parameter int LOCK_CNT    = 16,  // consecutive matches to declare lock (1..255)
  parameter int WINDOW      = 64,  // loss-of-lock window in valid bits (2..65535)
  parameter int LOSS_THRESH = 4,   // errors per window that force loss (1..WINDOW)
  parameter int CNT_W       = 16   // width of the saturating error counter
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic [7:0]           tap,
  prbs_checker_if.slave        link
);

  localparam logic [7:0]  LOCK_LAST = 8'(LOCK_CNT - 1);
  localparam logic [15:0] WIN_LAST  = 16'(WINDOW - 1);
  localparam logic [15:0] LOSS_LIM  = 16'(LOSS_THRESH);

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;

  state_e           state_q,     state_d;
  logic [7:0]       sr_q,        sr_d;
  logic [7:0]       tap_q,       tap_d;
  logic [2:0]       fill_q,      fill_d;
  logic [7:0]       match_q,     match_d;
  logic [15:0]      win_cnt_q,   win_cnt_d;
  logic [15:0]      win_err_q,   win_err_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic             err_pulse_q, err_pulse_d;

  logic        pred;
  logic        mismatch;
  logic [15:0] win_err_sum;

  // sr_q[0] holds the most recently accepted bit, so the prediction is the
  // generator's own next-bit rule applied to the local register.
  assign pred        = ^(sr_q & tap_q);
  assign mismatch    = link.bit_in ^ pred;
  // Errors seen so far in this window including the current beat; the loss
  // test uses this before any window rollover clears win_err.
  assign win_err_sum = win_err_q + 16'(mismatch);

  // NOTE: every signal written here gets its hold/default value first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    tap_d       = tap_q;
    fill_d      = fill_q;
    match_d     = match_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    err_count_d = err_count_q;
    err_pulse_d = 1'b0;

    if (clear) begin
      state_d     = SEED;
      tap_d       = tap;
      fill_d      = '0;
      match_d     = '0;
      win_cnt_d   = '0;
      win_err_d   = '0;
      err_count_d = '0;
    end else if (link.bit_valid) begin
      unique case (state_q)
        SEED: begin
          sr_d   = {sr_q[6:0], link.bit_in};
          fill_d = fill_q + 3'd1;
          if (fill_q == 3'd7) begin
            state_d = VERIFY;
            match_d = '0;
          end
        end

        VERIFY: begin
          // Always follow the line here: this is the self-synchronising step.
          sr_d = {sr_q[6:0], link.bit_in};
          // An all-zero register predicts zero forever, so it never counts
          // as a match even when the line is also stuck at zero.
          if (!mismatch && (sr_q != 8'd0)) begin
            match_d = match_q + 8'd1;
            if (match_q == LOCK_LAST) begin
              state_d   = LOCKED;
              win_cnt_d = '0;
              win_err_d = '0;
            end
          end else begin
            match_d = '0;
          end
        end

        LOCKED: begin
          // Flywheel: shift in the prediction, never the line bit, so one
          // line error produces exactly one counted error.
          sr_d = {sr_q[6:0], pred};
          if (mismatch) begin
            err_pulse_d = 1'b1;
            if (err_count_q != '1) err_count_d = err_count_q + CNT_W'(1);
          end
          if (win_cnt_q == WIN_LAST) begin
            win_cnt_d = '0;
            win_err_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + 16'd1;
            win_err_d = win_err_sum;
          end
          if (win_err_sum >= LOSS_LIM) begin
            state_d = SEED;
            fill_d  = '0;
          end
        end

        default: state_d = SEED;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values computed before the edge regardless of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= SEED;
      sr_q        <= '0;
      // NOTE: tap is captured (not cleared) during reset so the checker
      // comes out of reset already holding the link's polynomial.
      tap_q       <= tap;
      fill_q      <= '0;
      match_q     <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      err_count_q <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      tap_q       <= tap_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      err_count_q <= err_count_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  assign link.locked    = (state_q == LOCKED);
  assign link.err_pulse = err_pulse_q;
  assign link.err_count = err_count_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Testbench for prbs_checker. Two instances share one stimulus stream: a
// 16-bit error counter and a 4-bit one to exercise saturation. A reference
// model built from the protocol rules predicts every cycle's outputs; the
// driver queues predictions and a monitor compares them against both DUTs.
module tb_prbs_checker;

  localparam int LOCK_CNT    = 16;
  localparam int WINDOW      = 64;
  localparam int LOSS_THRESH = 4;
  localparam logic [7:0] GEN_TAP = 8'hB8;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic [7:0] tap;

  prbs_checker_if #(.CNT_W(16)) if16 ();
  prbs_checker_if #(.CNT_W(4))  if4  ();

  prbs_checker #(.LOCK_CNT(LOCK_CNT), .WINDOW(WINDOW), .LOSS_THRESH(LOSS_THRESH), .CNT_W(16)) dut16 (
    .clk(clk), .reset(reset), .clear(clear), .tap(tap), .link(if16.slave));
  prbs_checker #(.LOCK_CNT(LOCK_CNT), .WINDOW(WINDOW), .LOSS_THRESH(LOSS_THRESH), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .clear(clear), .tap(tap), .link(if4.slave));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit lk;
    bit ep;
    int cnt16;
    int cnt4;
  } exp_t;

  exp_t exp_q[$];

  int         m_mode;    // 0 = filling, 1 = verifying, 2 = locked
  bit         hist[$];   // last received bits, newest at the back
  int         m_streak;
  logic [7:0] m_fly;
  int         m_beats;   // valid beats since lock
  int         m_win;     // index of current window
  int         m_werr;
  int         m_total;
  bit         m_pulse;
  logic [7:0] m_tap;
  logic [7:0] g;         // generator state

  function automatic bit lfsr_bit(input logic [7:0] s, input logic [7:0] t);
    int ones = 0;
    for (int i = 0; i < 8; i++) if (s[i] && t[i]) ones++;
    return bit'(ones % 2);
  endfunction

  function automatic logic [7:0] hist_vec();
    logic [7:0] v = '0;
    for (int i = 0; i < hist.size(); i++) v[i] = hist[hist.size()-1-i];
    return v;
  endfunction

  task automatic model_reset();
    m_mode = 0; hist.delete(); m_streak = 0; m_total = 0; m_pulse = 0; m_tap = tap;
  endtask

  task automatic model_step(input bit v, input bit b, input bit clr);
    logic [7:0] vec;
    bit p;
    m_pulse = 0;
    if (clr) begin
      m_mode = 0; hist.delete(); m_streak = 0; m_total = 0; m_tap = tap;
    end else if (v) begin
      case (m_mode)
        0: begin
          hist.push_back(b);
          if (hist.size() == 8) begin m_mode = 1; m_streak = 0; end
        end
        1: begin
          vec = hist_vec();
          p   = lfsr_bit(vec, m_tap);
          hist.push_back(b);
          void'(hist.pop_front());
          if (b == p && vec != 0) begin
            m_streak++;
            if (m_streak == LOCK_CNT) begin
              m_mode = 2; m_fly = hist_vec(); m_beats = 0; m_win = 0; m_werr = 0;
            end
          end else m_streak = 0;
        end
        default: begin
          p     = lfsr_bit(m_fly, m_tap);
          m_fly = {m_fly[6:0], p};
          if (m_beats / WINDOW != m_win) begin m_win = m_beats / WINDOW; m_werr = 0; end
          m_beats++;
          if (b != p) begin
            m_pulse = 1; m_total++; m_werr++;
            if (m_werr >= LOSS_THRESH) begin m_mode = 0; hist.delete(); end
          end
        end
      endcase
    end
  endtask

  // ---------------- driver ----------------
  // Called at posedge+1; inputs are consumed at the next posedge, where the
  // matching prediction is queued for the monitor.
  task automatic beat(input bit v, input bit b, input bit clr);
    exp_t e;
    if16.bit_valid = v; if16.bit_in = b;
    if4.bit_valid  = v; if4.bit_in  = b;
    clear = clr;
    model_step(v, b, clr);
    e.lk    = (m_mode == 2);
    e.ep    = m_pulse;
    e.cnt16 = (m_total > 65535) ? 65535 : m_total;
    e.cnt4  = (m_total > 15) ? 15 : m_total;
    @(posedge clk);
    exp_q.push_back(e);
    #1;
    clear = 1'b0;
  endtask

  task automatic gen_beat(input bit v, input bit flip, input bit clr = 1'b0);
    bit b;
    if (v) begin
      b = lfsr_bit(g, GEN_TAP);
      g = {g[6:0], b};
      beat(1'b1, b ^ flip, clr);
    end else begin
      beat(1'b0, 1'($urandom_range(0, 1)), clr);
    end
  endtask

  task automatic clean(input int n);
    for (int i = 0; i < n; i++) gen_beat(1'b1, 1'b0);
  endtask

  // Reset asserted mid-cycle: outputs must drop with no clock edge.
  task automatic do_reset();
    @(posedge clk);
    #4;
    reset = 1'b1;
    if16.bit_valid = 1'b0; if4.bit_valid = 1'b0;
    model_reset();
    #1;
    check("async_locked",    if16.locked,    0);
    check("async_err_count", if16.err_count, 0);
    check("async_err_pulse", if16.err_pulse, 0);
    check("async_err_cnt_w4", if4.err_count, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("locked",       if16.locked,    e.lk);
        check("locked_w4",    if4.locked,     e.lk);
        check("err_pulse",    if16.err_pulse, e.ep);
        check("err_count",    if16.err_count, e.cnt16);
        check("err_count_w4", if4.err_count,  e.cnt4);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; clear = 1'b0; tap = GEN_TAP;
    if16.bit_in = 1'b0; if16.bit_valid = 1'b0;
    if4.bit_in  = 1'b0; if4.bit_valid  = 1'b0;
    g = 8'h01;
    model_reset();
    #1;
    check("reset_locked",    if16.locked,    0);
    check("reset_err_count", if16.err_count, 0);
    check("reset_err_pulse", if16.err_pulse, 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // Clean lock: exactly 24 valid beats.
    clean(23);
    check("lock_not_before_24", if16.locked, 0);
    clean(1);
    check("lock_at_24", if16.locked, 1);
    clean(1000);
    check("clean_err_count", if16.err_count, 0);

    // Single error: one pulse, one count, no propagation.
    gen_beat(1'b1, 1'b1);
    check("single_pulse", if16.err_pulse, 1);
    check("single_count", if16.err_count, 1);
    clean(1);
    check("single_pulse_gone", if16.err_pulse, 0);
    clean(20);
    check("single_count_hold", if16.err_count, 1);
    check("single_still_locked", if16.locked, 1);

    // Loss of lock: 4 errors within 14 beats of a fresh lock.
    beat(1'b0, 1'b0, 1'b1);
    check("clear_count", if16.err_count, 0);
    clean(24);
    check("relock_after_clear", if16.locked, 1);
    for (int i = 0; i < 14; i++) gen_beat(1'b1, (i % 4) == 1);
    check("loss_unlocked", if16.locked, 0);
    check("loss_count", if16.err_count, 4);
    clean(24);
    check("relock_after_loss", if16.locked, 1);

    // Window expiry: 3 errors, 64 clean, 3 errors -> stays locked.
    beat(1'b0, 1'b0, 1'b1);
    clean(24);
    for (int i = 0; i < 3; i++) gen_beat(1'b1, 1'b1);
    clean(64);
    for (int i = 0; i < 3; i++) gen_beat(1'b1, 1'b1);
    check("window_locked", if16.locked, 1);
    check("window_count", if16.err_count, 6);

    // Saturation: 6 lock/loss rounds of 4 errors each.
    beat(1'b0, 1'b0, 1'b1);
    for (int r = 0; r < 6; r++) begin
      clean(24);
      for (int i = 0; i < 4; i++) gen_beat(1'b1, 1'b1);
    end
    check("sat_count16", if16.err_count, 24);
    check("sat_count4",  if4.err_count,  15);

    // Reset while locked.
    clean(24);
    check("pre_reset_locked", if16.locked, 1);
    do_reset();

    // All-zero line never locks.
    for (int i = 0; i < 500; i++) beat(1'b1, 1'b0, 1'b0);
    check("zero_line_unlocked", if16.locked, 0);

    // Gapped stream: valid on alternate cycles.
    do_reset();
    for (int c = 0; c < 46; c++) gen_beat((c % 2) == 0, 1'b0);
    check("gap_not_before_24", if16.locked, 0);
    gen_beat(1'b1, 1'b0);
    check("gap_lock_at_24", if16.locked, 1);

    // clear during VERIFY restarts from SEED, even with a beat in that cycle.
    beat(1'b0, 1'b0, 1'b1);
    clean(12);
    gen_beat(1'b1, 1'b0, 1'b1);
    clean(23);
    check("clear_verify_not_locked", if16.locked, 0);
    clean(1);
    check("clear_verify_locked", if16.locked, 1);

    // Randomised traffic: gaps, sparse line errors, occasional clear.
    for (int i = 0; i < 3000; i++) begin
      gen_beat($urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0,
               $urandom_range(0, 499) == 0);
    end

    @(posedge clk); #5;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
